dtm_dmi_ctrl: RTL and testbench
===============================

Name: dtm_dmi_ctrl

Overview:
- JTAG Debug Transport Module controller for the tck domain, one per jtag_tap instance.
- Owns the DMI and DTMCS data registers that sit behind the jtag_tap capture/shift/update strobes.
- Turns each DMI update into one request/response transaction to the Debug Module.
- Tracks busy and sticky error status per the RISC-V debug spec; the DM-side clock crossing lives elsewhere.

Parameters:
- ABITS, 7, DMI address width; DMI register is ABITS+34 bits.
- IDLE_HINT, 3, value reported in dtmcs.idle[14:12].
- TIMEOUT_CYCLES, 255, tck cycles before abort (optional feature only).

Ports:
- tck  in  1  JTAG clock; all state on posedge.
- trst  in  1  asynchronous active-low reset.
- test_logic_reset  in  1  TAP in Test-Logic-Reset.
- capture_dr / shift_dr / update_dr  in  1 each  TAP DR strobes.
- dmi_select  in  1  IR selects DMI.
- dtmcs_select  in  1  IR selects DTMCS.
- tdi  in  1  serial data in.
- dmi_tdo  out  1  DMI shift register bit 0, combinational.
- dtmcs_tdo  out  1  DTMCS shift register bit 0, combinational.
- req_valid  out  1  request to DM.
- req_ready  in  1  DM accepts request.
- req_addr  out  ABITS  request address.
- req_data  out  32  request write data.
- req_op  out  2  1 = read, 2 = write.
- rsp_valid  in  1  DM response valid.
- rsp_ready  out  1  controller accepts response.
- rsp_data  in  32  read data.
- rsp_resp  in  2  0 = ok, 2 = failed, 3 = busy.

Behaviour:
- Reset (trst low, async): state IDLE; sticky dmistat = 0; shift registers, last_addr and last_data = 0; req_valid and rsp_ready = 0.
- test_logic_reset high: synchronously forces the same values as reset.
- FSM IDLE -> REQ -> WAIT -> IDLE.
  - req_valid = (state == REQ).
  - rsp_ready = (state == WAIT).
  - req_addr, req_data, req_op are registered and stable while in REQ.
- Capture, DMI: shift register loads {last_addr, last_data, opfield}.
  - opfield = 3 if state != IDLE; in that case sticky dmistat is also set to 3 if it was 0.
  - Otherwise opfield = dmistat.
- Capture, DTMCS: loads {14'b0, hardreset=0, dmireset=0, 1'b0, IDLE_HINT[2:0], dmistat, ABITS[5:0], 4'h1}.
- Shift: selected register shifts right one bit per cycle with tdi into the MSB; the unselected register holds.
- Update, DMI (decode shift register as {addr, data, op}):
  - state != IDLE: set dmistat = 3 if 0; no request issued.
  - dmistat != 0: ignore.
  - op 1 or 2: latch addr/data/op and last_addr; REQ next cycle.
  - op 0 or 3: no action.
- REQ: req_ready high -> WAIT. req_valid is never dropped without a handshake, except on abort.
- WAIT: on rsp_valid -> IDLE.
  - Read: last_data = rsp_data. Write: last_data unchanged.
  - rsp_resp 2: dmistat = 2 if 0. rsp_resp 3: dmistat = 3 if 0.
  - Sticky status is never overwritten by a different nonzero code.
- Update, DTMCS:
  - bit16 (dmireset): dmistat = 0.
  - bit17 (dmihardreset): abort; state IDLE, dmistat = 0, req_valid and rsp_ready low the next cycle, any in-flight response dropped.
  - Both bits set: hardreset behaviour (superset).
  - Other bits: read-only, writes ignored.
- Simultaneous events:
  - rsp_valid on the same edge as hardreset: response dropped.
  - capture and update in one cycle cannot occur; TAP guarantees one-hot strobes.

Optional Feature:
- Macro DTM_DMI_TIMEOUT_EN.
- Defined:
  - 8+-bit counter clears on entering REQ and counts every cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES: abort to IDLE, req_valid and rsp_ready low, dmistat = 2 if 0.
  - A late rsp_valid after the abort is ignored because rsp_ready is low.
- Undefined: no counter; REQ and WAIT wait indefinitely.

Decomposition:
- Package dm_pkg:
  - DMI op encodings (NOP/READ/WRITE) and response encodings (OK/FAILED/BUSY).
  - dtmcs field offsets (version, abits, dmistat, idle, dmireset, dmihardreset) and DTM version constant 4'h1.
  - FSM state enum.
- One sub-module, jtag_dr_shift: parameterised width, parallel load on capture, shift on shift_dr with tdi in at the MSB, bit 0 out.
  - Instantiated twice: width ABITS+34 for DMI, 32 for DTMCS.

Test Plan:
- Reset, ABITS=7: trst low then high, capture+shift DTMCS -> shifts out 0x00003071; req_valid = 0; rsp_ready = 0.
- Write: shift {addr=0x10, data=0x00000001, op=2}, update -> next cycle req_valid = 1, req_addr = 0x10, req_data = 1, req_op = 2. Then req_ready -> WAIT; rsp_valid with resp 0 -> IDLE; next DMI capture op = 0.
- Read: addr 0x11, op=1; DM returns rsp_data 0xDEADBEEF, resp 0 -> next capture shifts out addr 0x11, data 0xDEADBEEF, op 0.
- Busy: second update while in WAIT -> no new req_valid, capture op = 3, dtmcs dmistat = 3. Later valid ops are ignored until a DTMCS update with bit16 = 1; after that a read issues normally.
- Failed and abort: resp 2 -> dmistat = 2. Next request stuck in WAIT, then DTMCS update with bit17 = 1 -> rsp_ready low next cycle, dmistat = 0, state IDLE.
- DTM_DMI_TIMEOUT_EN, TIMEOUT_CYCLES = 255: req_ready held low -> req_valid drops after 255 cycles and dmistat = 2. Without the macro: req_valid is still high after 1000 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the JTAG Debug Transport Module: DMI op/response
// codes, dtmcs field positions, the DTM version and the DMI controller states.
package dm_pkg;

    // DMI op field as shifted in by the debugger
    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

    // DM response codes; dmistat and the captured op field use the same values
    localparam logic [1:0] DMI_RSP_OK     = 2'd0;
    localparam logic [1:0] DMI_RSP_FAILED = 2'd2;
    localparam logic [1:0] DMI_RSP_BUSY   = 2'd3;

    // dtmcs field offsets
    localparam int unsigned DTMCS_VERSION_LSB   = 0;
    localparam int unsigned DTMCS_ABITS_LSB     = 4;
    localparam int unsigned DTMCS_DMISTAT_LSB   = 10;
    localparam int unsigned DTMCS_IDLE_LSB      = 12;
    localparam int unsigned DTMCS_DMIRESET_BIT  = 16;
    localparam int unsigned DTMCS_HARDRESET_BIT = 17;

    localparam logic [3:0] DTM_VERSION = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } dmi_state_e;

    // Value loaded into the DTMCS shift register on Capture-DR
    function automatic logic [31:0] dtmcs_word(input logic [2:0] idle,
                                               input logic [1:0] dmistat,
                                               input logic [5:0] abits);
        logic [31:0] w;
        w = '0;
        w[DTMCS_VERSION_LSB +: 4] = DTM_VERSION;
        w[DTMCS_ABITS_LSB   +: 6] = abits;
        w[DTMCS_DMISTAT_LSB +: 2] = dmistat;
        w[DTMCS_IDLE_LSB    +: 3] = idle;
        return w;
    endfunction

endpackage

// File: rtl/jtag_dr_shift.sv
// Generic JTAG data-register shift stage: parallel load on capture, shift
// right with tdi entering at the MSB, bit 0 driven out as tdo.
module jtag_dr_shift #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_tdi,
    input  logic [WIDTH-1:0] i_load,
    output logic [WIDTH-1:0] o_value,
    output logic             o_tdo
);

    logic [WIDTH-1:0] r_sr;

    // Shift register: capture has priority over shift (TAP keeps them exclusive)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_clear) begin
            r_sr <= '0;
        end else if (i_capture) begin
            r_sr <= i_load;
        end else if (i_shift) begin
            r_sr <= {i_tdi, r_sr[WIDTH-1:1]};
        end
    end

    assign o_value = r_sr;
    assign o_tdo   = r_sr[0];

endmodule

// File: rtl/dtm_dmi_ctrl.sv
// JTAG DTM controller (tck domain): owns the DMI and DTMCS data registers,
// turns each DMI update into one request/response exchange with the Debug
// Module and tracks busy/sticky error status.
// Optional request timeout: define DTM_DMI_TIMEOUT_EN.
module dtm_dmi_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned ABITS          = 7,
    parameter int unsigned IDLE_HINT      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             tck,
    input  logic             trst,
    input  logic             test_logic_reset,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic             dmi_select,
    input  logic             dtmcs_select,
    input  logic             tdi,
    output logic             dmi_tdo,
    output logic             dtmcs_tdo,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [ABITS-1:0] req_addr,
    output logic [31:0]      req_data,
    output logic [1:0]       req_op,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_data,
    input  logic [1:0]       rsp_resp
);

    localparam int unsigned DMI_W = ABITS + 34;

    dmi_state_e       r_state, w_state_nxt;
    logic [1:0]       r_dmistat, w_dmistat_nxt;
    logic [ABITS-1:0] r_last_addr, w_last_addr_nxt;
    logic [31:0]      r_last_data, w_last_data_nxt;
    logic [ABITS-1:0] r_req_addr, w_req_addr_nxt;
    logic [31:0]      r_req_data, w_req_data_nxt;
    logic [1:0]       r_req_op, w_req_op_nxt;

    logic             w_dmi_capture, w_dmi_shift, w_dmi_update;
    logic             w_dtmcs_capture, w_dtmcs_shift, w_dtmcs_update;
    logic [DMI_W-1:0] w_dmi_load, w_dmi_val;
    logic [31:0]      w_dtmcs_load, w_dtmcs_val;
    logic [1:0]       w_dmi_opfield;
    logic [ABITS-1:0] w_upd_addr;
    logic [31:0]      w_upd_data;
    logic [1:0]       w_upd_op;
    logic             w_tmo_hit;
    logic             w_dtmcs_unused;

    assign w_dmi_capture   = capture_dr & dmi_select;
    assign w_dmi_shift     = shift_dr   & dmi_select;
    assign w_dmi_update    = update_dr  & dmi_select;
    assign w_dtmcs_capture = capture_dr & dtmcs_select;
    assign w_dtmcs_shift   = shift_dr   & dtmcs_select;
    assign w_dtmcs_update  = update_dr  & dtmcs_select;

    // A capture while a transaction is outstanding reports busy in the op field
    assign w_dmi_opfield = (r_state != ST_IDLE) ? DMI_RSP_BUSY : r_dmistat;
    assign w_dmi_load    = {r_last_addr, r_last_data, w_dmi_opfield};
    assign w_dtmcs_load  = dtmcs_word(3'(IDLE_HINT), r_dmistat, 6'(ABITS));

    assign {w_upd_addr, w_upd_data, w_upd_op} = w_dmi_val;

    // Only dmireset/dmihardreset are writable in dtmcs
    assign w_dtmcs_unused = ^{w_dtmcs_val[31:DTMCS_HARDRESET_BIT+1],
                              w_dtmcs_val[DTMCS_DMIRESET_BIT-1:0]};

    jtag_dr_shift #(.WIDTH(DMI_W)) u_dmi_dr (
        .i_clk     (tck),
        .i_rst_n   (trst),
        .i_clear   (test_logic_reset),
        .i_capture (w_dmi_capture),
        .i_shift   (w_dmi_shift),
        .i_tdi     (tdi),
        .i_load    (w_dmi_load),
        .o_value   (w_dmi_val),
        .o_tdo     (dmi_tdo)
    );

    jtag_dr_shift #(.WIDTH(32)) u_dtmcs_dr (
        .i_clk     (tck),
        .i_rst_n   (trst),
        .i_clear   (test_logic_reset),
        .i_capture (w_dtmcs_capture),
        .i_shift   (w_dtmcs_shift),
        .i_tdi     (tdi),
        .i_load    (w_dtmcs_load),
        .o_value   (w_dtmcs_val),
        .o_tdo     (dtmcs_tdo)
    );

`ifdef DTM_DMI_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;

    // Fires on the last allowed cycle so the abort lands exactly TIMEOUT_CYCLES after entry
    assign w_tmo_hit = (r_state != ST_IDLE) &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter next value: cleared on entry to REQ, counts through REQ and WAIT
    always_comb begin
        w_tmo_cnt_nxt = r_tmo_cnt;
        if ((w_state_nxt == ST_REQ) && (r_state != ST_REQ)) begin
            w_tmo_cnt_nxt = '0;
        end else if (r_state != ST_IDLE) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_tmo_cnt <= '0;
        end else if (test_logic_reset) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end
`else
    logic w_tmo_unused;

    assign w_tmo_hit    = 1'b0;
    assign w_tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state and datapath decode; later blocks override earlier ones so
    // hardreset wins over a same-cycle response and timeout wins over handshakes
    always_comb begin
        w_state_nxt     = r_state;
        w_dmistat_nxt   = r_dmistat;
        w_last_addr_nxt = r_last_addr;
        w_last_data_nxt = r_last_data;
        w_req_addr_nxt  = r_req_addr;
        w_req_data_nxt  = r_req_data;
        w_req_op_nxt    = r_req_op;

        if (w_tmo_hit) begin
            w_state_nxt = ST_IDLE;
            if (r_dmistat == DMI_RSP_OK) begin
                w_dmistat_nxt = DMI_RSP_FAILED;
            end
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_REQ: begin
                    if (req_ready) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        w_state_nxt = ST_IDLE;
                        if (r_req_op == DMI_OP_READ) begin
                            w_last_data_nxt = rsp_data;
                        end
                        if (r_dmistat == DMI_RSP_OK) begin
                            case (rsp_resp)
                                DMI_RSP_FAILED: w_dmistat_nxt = DMI_RSP_FAILED;
                                DMI_RSP_BUSY:   w_dmistat_nxt = DMI_RSP_BUSY;
                                default:        ;
                            endcase
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (w_dmi_capture && (r_state != ST_IDLE) && (w_dmistat_nxt == DMI_RSP_OK)) begin
            w_dmistat_nxt = DMI_RSP_BUSY;
        end

        if (w_dmi_update) begin
            if (r_state != ST_IDLE) begin
                if (w_dmistat_nxt == DMI_RSP_OK) begin
                    w_dmistat_nxt = DMI_RSP_BUSY;
                end
            end else if (r_dmistat == DMI_RSP_OK) begin
                case (w_upd_op)
                    DMI_OP_READ, DMI_OP_WRITE: begin
                        w_req_addr_nxt  = w_upd_addr;
                        w_req_data_nxt  = w_upd_data;
                        w_req_op_nxt    = w_upd_op;
                        w_last_addr_nxt = w_upd_addr;
                        w_state_nxt     = ST_REQ;
                    end
                    DMI_OP_NOP, DMI_OP_RSVD: ;
                    default: ;
                endcase
            end
        end

        if (w_dtmcs_update) begin
            if (w_dtmcs_val[DTMCS_HARDRESET_BIT]) begin
                w_state_nxt     = ST_IDLE;
                w_dmistat_nxt   = DMI_RSP_OK;
                w_last_data_nxt = r_last_data;
            end else if (w_dtmcs_val[DTMCS_DMIRESET_BIT]) begin
                w_dmistat_nxt = DMI_RSP_OK;
            end
        end
    end

    // State and datapath registers; Test-Logic-Reset mirrors trst synchronously
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_state     <= ST_IDLE;
            r_dmistat   <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_op    <= '0;
        end else if (test_logic_reset) begin
            r_state     <= ST_IDLE;
            r_dmistat   <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_op    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dmistat   <= w_dmistat_nxt;
            r_last_addr <= w_last_addr_nxt;
            r_last_data <= w_last_data_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_req_data  <= w_req_data_nxt;
            r_req_op    <= w_req_op_nxt;
        end
    end

    assign req_valid = (r_state == ST_REQ);
    assign rsp_ready = (r_state == ST_WAIT);
    assign req_addr  = r_req_addr;
    assign req_data  = r_req_data;
    assign req_op    = r_req_op;

endmodule

// File: tb/tb_dtm_dmi_ctrl.sv
// Scoreboard bench for dtm_dmi_ctrl (ABITS=7, IDLE_HINT=3, TIMEOUT_CYCLES=255).
module tb_dtm_dmi_ctrl;

    logic        tck = 1'b0;
    logic        trst, test_logic_reset;
    logic        capture_dr, shift_dr, update_dr, dmi_select, dtmcs_select, tdi;
    logic        dmi_tdo, dtmcs_tdo;
    logic        req_valid, req_ready;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [63:0] cap_q[$];
    logic [63:0] req_q[$];

    dtm_dmi_ctrl #(.ABITS(7), .IDLE_HINT(3), .TIMEOUT_CYCLES(255)) dut (
        .tck              (tck),
        .trst             (trst),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .dmi_select       (dmi_select),
        .dtmcs_select     (dtmcs_select),
        .tdi              (tdi),
        .dmi_tdo          (dmi_tdo),
        .dtmcs_tdo        (dtmcs_tdo),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_op           (req_op),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_resp         (rsp_resp)
    );

    always #5 tck = ~tck;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full DR scan: capture, shift n bits, update. Expected capture goes through the scoreboard.
    task automatic scan(input bit is_dmi, input logic [63:0] din, input logic [63:0] exp_cap,
                        input string tag);
        logic [63:0] dout;
        int unsigned n;
        n = is_dmi ? 41 : 32;
        cap_q.push_back(exp_cap);
        @(negedge tck);
        dmi_select   = is_dmi;
        dtmcs_select = !is_dmi;
        capture_dr   = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        dout = '0;
        for (int unsigned i = 0; i < n; i++) begin
            dout[i] = is_dmi ? dmi_tdo : dtmcs_tdo;
            tdi = din[i];
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        tdi       = 1'b0;
        @(negedge tck);
        update_dr    = 1'b0;
        dmi_select   = 1'b0;
        dtmcs_select = 1'b0;
        chk(tag, dout, cap_q.pop_front());
    endtask

    // DMI scan that should launch a request on the following cycle
    task automatic issue(input string tag, input logic [6:0] a, input logic [31:0] d,
                         input logic [1:0] op, input logic [63:0] exp_cap);
        req_q.push_back(dmi_word(a, d, op));
        scan(1'b1, dmi_word(a, d, op), exp_cap, {tag, "_cap"});
        chk({tag, "_valid"}, req_valid, 1);
    endtask

    task automatic dm_accept(input string tag);
        int unsigned n = 0;
        while (!req_valid && n < 50) begin
            @(negedge tck);
            n++;
        end
        chk({tag, "_seen"}, req_valid, 1);
        chk({tag, "_req"}, dmi_word(req_addr, req_data, req_op),
            (req_q.size() > 0) ? req_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF);
        req_ready = 1'b1;
        @(negedge tck);
        req_ready = 1'b0;
        chk({tag, "_wait"}, {req_valid, rsp_ready}, 2'b01);
    endtask

    task automatic dm_respond(input string tag, input logic [31:0] d, input logic [1:0] r);
        rsp_valid = 1'b1;
        rsp_data  = d;
        rsp_resp  = r;
        @(negedge tck);
        rsp_valid = 1'b0;
        chk({tag, "_done"}, rsp_ready, 0);
    endtask

    initial begin
        int unsigned n;
        trst = 1'b0; test_logic_reset = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        dmi_select = 1'b0; dtmcs_select = 1'b0; tdi = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_resp = '0;

        repeat (3) @(negedge tck);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_rsp_ready", rsp_ready, 0);
        chk("rst_tdo", {dmi_tdo, dtmcs_tdo}, 2'b00);
        chk("rst_req_op", req_op, 0);
        trst = 1'b1;
        @(negedge tck);

        scan(1'b0, 64'h0, 64'h3071, "dtmcs_rst");
        chk("idle_handshake", {req_valid, rsp_ready}, 2'b00);

        // write: last_data must not pick up the response data
        issue("wr", 7'h10, 32'h1, 2'd2, dmi_word(7'h0, 32'h0, 2'd0));
        dm_accept("wr");
        dm_respond("wr", 32'h1234_5678, 2'd0);
        scan(1'b1, 64'h0, dmi_word(7'h10, 32'h0, 2'd0), "wr_after");

        // read
        issue("rd", 7'h11, 32'h0, 2'd1, dmi_word(7'h10, 32'h0, 2'd0));
        dm_accept("rd");
        dm_respond("rd", 32'hDEAD_BEEF, 2'd0);
        scan(1'b1, 64'h0, dmi_word(7'h11, 32'hDEAD_BEEF, 2'd0), "rd_after");

        // busy: update while WAIT
        issue("bz", 7'h12, 32'h0, 2'd1, dmi_word(7'h11, 32'hDEAD_BEEF, 2'd0));
        dm_accept("bz");
        scan(1'b1, dmi_word(7'h13, 32'h55, 2'd2), dmi_word(7'h12, 32'hDEAD_BEEF, 2'd3), "bz_cap");
        chk("bz_no_new_req", {req_valid, rsp_ready}, 2'b01);
        scan(1'b0, 64'h0, 64'h3C71, "bz_dtmcs");
        dm_respond("bz", 32'hCAFE_F00D, 2'd0);
        scan(1'b1, dmi_word(7'h14, 32'h0, 2'd1), dmi_word(7'h12, 32'hCAFE_F00D, 2'd3), "bz_sticky");
        repeat (3) @(negedge tck);
        chk("bz_ignored", req_valid, 0);
        scan(1'b0, 64'h1 << 16, 64'h3C71, "dmireset_cap");
        scan(1'b0, 64'h0, 64'h3071, "dmireset_done");

        // failed response
        issue("rd2", 7'h15, 32'h0, 2'd1, dmi_word(7'h12, 32'hCAFE_F00D, 2'd0));
        dm_accept("rd2");
        dm_respond("rd2", 32'h0BAD_F00D, 2'd2);
        scan(1'b0, 64'h1 << 16, 64'h3871, "fail_stat");

        // hardreset while stuck in WAIT, then a late response
        issue("wr2", 7'h16, 32'hA5A5_A5A5, 2'd2, dmi_word(7'h15, 32'h0BAD_F00D, 2'd0));
        dm_accept("wr2");
        repeat (5) @(negedge tck);
        chk("stuck_wait", rsp_ready, 1);
        scan(1'b0, 64'h1 << 17, 64'h3071, "hr_cap");
        chk("hr_abort", {req_valid, rsp_ready}, 2'b00);
        rsp_valid = 1'b1; rsp_resp = 2'd2; rsp_data = 32'hFFFF_FFFF;
        repeat (2) @(negedge tck);
        rsp_valid = 1'b0;
        scan(1'b0, 64'h0, 64'h3071, "hr_stat");
        scan(1'b1, 64'h0, dmi_word(7'h16, 32'h0BAD_F00D, 2'd0), "hr_dmi");

        // both reset bits while held in REQ
        issue("rq3", 7'h17, 32'h0, 2'd1, dmi_word(7'h16, 32'h0BAD_F00D, 2'd0));
        scan(1'b1, 64'h0, dmi_word(7'h17, 32'h0BAD_F00D, 2'd3), "rq3_cap");
        chk("rq3_hold_valid", req_valid, 1);
        chk("rq3_hold_req", dmi_word(req_addr, req_data, req_op), req_q.pop_front());
        scan(1'b0, 64'h3 << 16, 64'h3C71, "both_cap");
        chk("both_abort", req_valid, 0);
        scan(1'b0, 64'h0, 64'h3071, "both_stat");

        // request never accepted
        issue("tmo", 7'h18, 32'h0, 2'd1, dmi_word(7'h17, 32'h0BAD_F00D, 2'd0));
        chk("tmo_req", dmi_word(req_addr, req_data, req_op), req_q.pop_front());
`ifdef DTM_DMI_TIMEOUT_EN
        n = 0;
        while (req_valid && n < 400) begin
            n++;
            @(negedge tck);
        end
        chk("tmo_len", 64'(n), 64'd255);
        scan(1'b0, 64'h1 << 16, 64'h3871, "tmo_stat");
`else
        n = 0;
        repeat (1000) @(negedge tck);
        chk("notmo_hold", req_valid, 1);
        scan(1'b0, 64'h1 << 17, 64'h3071, "notmo_hr");
        chk("notmo_abort", req_valid, 0);
`endif

        // Test-Logic-Reset clears everything
        @(negedge tck);
        test_logic_reset = 1'b1;
        @(negedge tck);
        test_logic_reset = 1'b0;
        scan(1'b1, 64'h0, 64'h0, "tlr_dmi");
        scan(1'b0, 64'h0, 64'h3071, "tlr_dtmcs");

        chk("sb_empty", 64'(cap_q.size() + req_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
